// File: rtl/wb_trace_checker.sv
// Writeback trace checker: buffers DUT retire records and compares them in order against a
// golden reference stream, latching the first failure cause.
module wb_trace_checker #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        chk_en,
   input  logic        debug_wb_have_inst,
   input  logic [31:0] debug_wb_pc,
   input  logic        debug_wb_ena,
   input  logic [4:0]  debug_wb_reg,
   input  logic [31:0] debug_wb_value,
   input  logic        ref_valid,
   output logic        ref_ready,
   input  logic [31:0] ref_pc,
   input  logic        ref_ena,
   input  logic [4:0]  ref_reg,
   input  logic [31:0] ref_value,
   input  logic        ref_last,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic [1:0]  err_code,
   output logic [31:0] err_pc,
   output logic [31:0] inst_cnt
);

   localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT - 1);

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISMATCH = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPass,
      StFail
   } state_t;

   state_t state;

   logic [31:0] fifo_pc    [FIFO_DEPTH];
   logic        fifo_ena   [FIFO_DEPTH];
   logic [4:0]  fifo_reg   [FIFO_DEPTH];
   logic [31:0] fifo_value [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   idle_cnt;

   logic        in_run;
   logic        fifo_empty;
   logic        fifo_full;
   logic        handshake;
   logic        push;
   logic        wr_en;
   logic [31:0] head_pc;
   logic        head_ena;
   logic [4:0]  head_reg;
   logic [31:0] head_value;
   logic        rec_match;
   logic        mismatch;
   logic        overflow;
   logic        timeout;
   logic        fail_now;
   logic        pass_now;
   logic [1:0]  fail_cause;
   logic [31:0] fail_pc;

   always_comb begin
      in_run     = (state == StRun);
      fifo_empty = (count == '0);
      fifo_full  = (count == FULL_CNT);
      ref_ready  = in_run && !fifo_empty;
      handshake  = ref_valid && ref_ready;
      push       = in_run && debug_wb_have_inst;
      // A pop in the same cycle frees the slot the push lands in.
      wr_en      = push && (!fifo_full || handshake);

      head_pc    = fifo_pc[rd_ptr];
      head_ena   = fifo_ena[rd_ptr];
      head_reg   = fifo_reg[rd_ptr];
      head_value = fifo_value[rd_ptr];

      // Writes to x0 are architecturally discarded, so their value is not compared.
      rec_match  = (head_pc == ref_pc) && (head_ena == ref_ena) &&
                   (!head_ena || ((head_reg == ref_reg) &&
                                  ((head_reg == 5'd0) || (head_value == ref_value))));

      mismatch   = handshake && !rec_match;
      overflow   = push && fifo_full && !handshake;
      timeout    = in_run && !push && !handshake && (idle_cnt == IDLE_LIMIT);
      fail_now   = mismatch || overflow || timeout;
      pass_now   = handshake && rec_match && ref_last;

      if (mismatch) begin
         fail_cause = ERR_MISMATCH;
         fail_pc    = head_pc;
      end else if (overflow) begin
         fail_cause = ERR_OVERFLOW;
         fail_pc    = debug_wb_pc;
      end else begin
         fail_cause = ERR_TIMEOUT;
         fail_pc    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         fifo_pc[wr_ptr]    <= debug_wb_pc;
         fifo_ena[wr_ptr]   <= debug_wb_ena;
         fifo_reg[wr_ptr]   <= debug_wb_reg;
         fifo_value[wr_ptr] <= debug_wb_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         idle_cnt <= '0;
         busy     <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         err_code <= ERR_NONE;
         err_pc   <= '0;
         inst_cnt <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (chk_en) begin
                  state    <= StRun;
                  busy     <= 1'b1;
                  idle_cnt <= '0;
               end
            end
            StRun: begin
               if (wr_en) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
               if (handshake) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
               if (wr_en && !handshake) begin
                  count <= count + 1'b1;
               end else if (!wr_en && handshake) begin
                  count <= count - 1'b1;
               end
               idle_cnt <= (push || handshake) ? '0 : idle_cnt + 1'b1;

               if (fail_now) begin
                  state    <= StFail;
                  busy     <= 1'b0;
                  fail     <= 1'b1;
                  err_code <= fail_cause;
                  err_pc   <= fail_pc;
               end else begin
                  if (handshake) begin
                     inst_cnt <= inst_cnt + 1'b1;
                  end
                  if (pass_now) begin
                     state <= StPass;
                     busy  <= 1'b0;
                     pass  <= 1'b1;
                  end
               end
            end
            StPass, StFail: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Randomised and directed bench for wb_trace_checker against a queue-based reference model.
module tb_wb_trace_checker;

   localparam int DEPTH = 8;
   localparam int TMO   = 16;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_PASS = 2;
   localparam int M_FAIL = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, chk_en, have;
   logic [31:0] wpc, wval;
   logic        wena;
   logic [4:0]  wreg;
   logic        ref_valid, ref_ready;
   logic [31:0] rpc, rval;
   logic        rena, rlast;
   logic [4:0]  rreg;
   logic        busy, pass, fail;
   logic [1:0]  err_code;
   logic [31:0] err_pc, inst_cnt;

   wb_trace_checker #(
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT   (TMO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .chk_en            (chk_en),
      .debug_wb_have_inst(have),
      .debug_wb_pc       (wpc),
      .debug_wb_ena      (wena),
      .debug_wb_reg      (wreg),
      .debug_wb_value    (wval),
      .ref_valid         (ref_valid),
      .ref_ready         (ref_ready),
      .ref_pc            (rpc),
      .ref_ena           (rena),
      .ref_reg           (rreg),
      .ref_value         (rval),
      .ref_last          (rlast),
      .busy              (busy),
      .pass              (pass),
      .fail              (fail),
      .err_code          (err_code),
      .err_pc            (err_pc),
      .inst_cnt          (inst_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rg;
      logic [31:0] val;
   } rec_t;

   int errors = 0;
   int checks = 0;

   // Reference model state
   rec_t        mq[$];
   int          m_state = M_IDLE;
   int          m_idle  = 0;
   logic [1:0]  m_code  = 2'd0;
   logic [31:0] m_pc    = 32'd0;
   logic [31:0] m_cnt   = 32'd0;

   // Stimulus streams: DUT-side records and the golden records offered on the ref port
   rec_t prog[$];
   rec_t rprog[$];
   int   wi = 0;
   int   ri = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit rec_match(input rec_t d, input rec_t r);
      if (d.pc != r.pc || d.ena != r.ena) return 1'b0;
      if (!d.ena) return 1'b1;
      if (d.rg != r.rg) return 1'b0;
      return (d.rg == 5'd0) || (d.val == r.val);
   endfunction

   // One clock: check ref_ready, advance the model, then compare registered outputs.
   task automatic cycle();
      bit   hs, psh, full;
      rec_t d, r, h;
      check_eq("ref_ready", 64'(ref_ready), 64'(m_state == M_RUN && mq.size() > 0));
      d = {wpc, wena, wreg, wval};
      r = {rpc, rena, rreg, rval};
      if (rst) begin
         m_state = M_IDLE;
         mq.delete();
         m_idle = 0;
         m_code = 2'd0;
         m_pc   = 32'd0;
         m_cnt  = 32'd0;
      end else if (m_state == M_IDLE) begin
         if (chk_en) m_state = M_RUN;
      end else if (m_state == M_RUN) begin
         hs   = ref_valid && mq.size() > 0;
         psh  = have;
         full = (mq.size() == DEPTH);
         h    = hs ? mq[0] : '0;
         if (hs && !rec_match(h, r)) begin
            m_state = M_FAIL; m_code = 2'd1; m_pc = h.pc;
         end else if (psh && full && !hs) begin
            m_state = M_FAIL; m_code = 2'd2; m_pc = d.pc;
         end else if (!psh && !hs && m_idle == TMO - 1) begin
            m_state = M_FAIL; m_code = 2'd3; m_pc = 32'd0;
         end else begin
            if (hs) begin
               void'(mq.pop_front());
               m_cnt++;
               if (rlast) m_state = M_PASS;
            end
            if (psh) mq.push_back(d);
            m_idle = (psh || hs) ? 0 : m_idle + 1;
         end
      end
      @(posedge clk);
      #1;
      check_eq("status", 64'({busy, pass, fail, err_code}),
               64'({m_state == M_RUN, m_state == M_PASS, m_state == M_FAIL, m_code}));
      check_eq("err_pc", 64'(err_pc), 64'(m_pc));
      check_eq("inst_cnt", 64'(inst_cnt), 64'(m_cnt));
      @(negedge clk);
   endtask

   task automatic drive(input bit do_push, input bit do_ref);
      have      = 1'b0;
      ref_valid = 1'b0;
      rlast     = 1'b0;
      if (do_push && wi < prog.size()) begin
         {wpc, wena, wreg, wval} = prog[wi];
         have = 1'b1;
         wi++;
      end
      if (do_ref && ri < rprog.size()) begin
         {rpc, rena, rreg, rval} = rprog[ri];
         rlast     = (ri == rprog.size() - 1);
         ref_valid = 1'b1;
         if (m_state == M_RUN && mq.size() > 0) ri++;
      end
      cycle();
   endtask

   // Golden copy differs only in fields the match rule ignores.
   task automatic make_prog(input int n);
      rec_t x;
      prog.delete();
      rprog.delete();
      wi = 0;
      ri = 0;
      for (int i = 0; i < n; i++) begin
         x.pc  = 32'(i * 4);
         x.ena = 1'($urandom_range(0, 1));
         x.rg  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         x.val = $urandom;
         prog.push_back(x);
         if (!x.ena) begin
            x.rg  = 5'($urandom_range(0, 31));
            x.val = $urandom;
         end else if (x.rg == 5'd0) begin
            x.val = $urandom;
         end
         rprog.push_back(x);
      end
   endtask

   task automatic corrupt(input int i);
      rec_t r;
      r = rprog[i];
      case ($urandom_range(0, 3))
         0:       r.pc  = r.pc ^ 32'h4;
         1:       r.ena = ~r.ena;
         2:       r.rg  = r.rg ^ 5'(1 << $urandom_range(0, 4));
         default: r.val = r.val ^ (32'(1) << $urandom_range(0, 31));
      endcase
      rprog[i] = r;
   endtask

   task automatic start();
      have = 1'b0; ref_valid = 1'b0; chk_en = 1'b1;
      cycle();
      chk_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; have = 1'b1; chk_en = 1'b1; ref_valid = 1'b0;
      cycle();
      rst = 1'b0; have = 1'b0; chk_en = 1'b0;
   endtask

   task automatic noise(input int n);
      for (int i = 0; i < n; i++) begin
         have      = 1'($urandom_range(0, 1));
         ref_valid = 1'($urandom_range(0, 1));
         chk_en    = 1'($urandom_range(0, 1));
         wpc       = $urandom;
         rpc       = $urandom;
         cycle();
      end
      have = 1'b0; ref_valid = 1'b0; chk_en = 1'b0;
   endtask

   task automatic run_random(input int n, input int p_push, input int p_ref, input int p_bad);
      make_prog(n);
      for (int i = 0; i < n; i++) begin
         if (int'($urandom_range(0, 99)) < p_bad) corrupt(i);
      end
      start();
      for (int c = 0; c < 300 && m_state == M_RUN; c++) begin
         chk_en = 1'($urandom_range(0, 1));
         drive(int'($urandom_range(0, 99)) < p_push, int'($urandom_range(0, 99)) < p_ref);
      end
      chk_en = 1'b0;
      noise(4);
      do_reset();
   endtask

   initial begin
      rst = 1'b1; chk_en = 1'b0; have = 1'b0; ref_valid = 1'b0; rlast = 1'b0;
      wpc = '0; wena = 1'b0; wreg = '0; wval = '0;
      rpc = '0; rena = 1'b0; rreg = '0; rval = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle();
      check_eq("reset_outputs", 64'({busy, pass, fail, err_code, ref_ready}), 64'(0));
      check_eq("reset_cnt", 64'(inst_cnt), 64'(0));

      // Five matching records, last on pc 0x10
      make_prog(5);
      start();
      repeat (5) drive(1'b1, 1'b0);
      repeat (5) drive(1'b0, 1'b1);
      check_eq("match_pass", 64'({pass, fail}), 64'(2'b10));
      check_eq("match_cnt", 64'(inst_cnt), 64'(5));
      do_reset();

      // Value mismatch on third record
      make_prog(5);
      prog[2]  = {32'h8, 1'b1, 5'd7, 32'h6};
      rprog[2] = {32'h8, 1'b1, 5'd7, 32'h5};
      start();
      repeat (5) drive(1'b1, 1'b0);
      repeat (3) drive(1'b0, 1'b1);
      check_eq("mism_state", 64'({fail, err_code}), 64'({1'b1, 2'd1}));
      check_eq("mism_pc", 64'(err_pc), 64'(32'h8));
      check_eq("mism_cnt", 64'(inst_cnt), 64'(2));
      do_reset();

      // Write to x0 ignores value
      make_prog(3);
      prog[1]  = {32'h4, 1'b1, 5'd0, 32'h1};
      rprog[1] = {32'h4, 1'b1, 5'd0, 32'hFFFF_FFFF};
      start();
      repeat (3) drive(1'b1, 1'b0);
      repeat (2) drive(1'b0, 1'b1);
      check_eq("x0_cnt", 64'(inst_cnt), 64'(2));
      drive(1'b0, 1'b1);
      check_eq("x0_pass", 64'({pass, fail}), 64'(2'b10));
      do_reset();

      // Overflow on ninth push
      make_prog(9);
      start();
      repeat (9) drive(1'b1, 1'b0);
      check_eq("ovf_state", 64'({fail, err_code}), 64'({1'b1, 2'd2}));
      check_eq("ovf_pc", 64'(err_pc), 64'(32'h20));
      do_reset();

      // Push and pop together while full is legal
      make_prog(12);
      start();
      repeat (8) drive(1'b1, 1'b0);
      repeat (4) drive(1'b1, 1'b1);
      check_eq("full_pp_nofail", 64'({busy, fail}), 64'(2'b10));
      repeat (8) drive(1'b0, 1'b1);
      check_eq("full_pp_pass", 64'({pass, fail}), 64'(2'b10));
      check_eq("full_pp_cnt", 64'(inst_cnt), 64'(12));
      do_reset();

      // Timeout exactly TMO cycles after entering RUN
      start();
      repeat (TMO - 1) drive(1'b0, 1'b0);
      check_eq("tmo_early", 64'({busy, fail}), 64'(2'b10));
      drive(1'b0, 1'b0);
      check_eq("tmo_state", 64'({fail, err_code}), 64'({1'b1, 2'd3}));
      check_eq("tmo_pc", 64'(err_pc), 64'(0));
      do_reset();

      // Reset mid-run with records queued, then a fresh run
      make_prog(5);
      start();
      repeat (5) drive(1'b1, 1'b0);
      repeat (3) drive(1'b0, 1'b1);
      do_reset();
      check_eq("midrst_flags", 64'({busy, pass, fail, err_code, ref_ready}), 64'(0));
      check_eq("midrst_pc_cnt", 64'({err_pc, inst_cnt}), 64'(0));
      make_prog(4);
      start();
      repeat (4) drive(1'b1, 1'b0);
      repeat (4) drive(1'b0, 1'b1);
      check_eq("fresh_pass", 64'({pass, fail}), 64'(2'b10));
      check_eq("fresh_cnt", 64'(inst_cnt), 64'(4));
      do_reset();

      for (int k = 0; k < 16; k++) begin
         run_random(int'($urandom_range(4, 30)), int'($urandom_range(30, 95)),
                    int'($urandom_range(20, 95)),
                    (k % 3 == 0) ? 0 : int'($urandom_range(2, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
